// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: power-down/up sequencer for a switchable domain (isolation, retention, switch, domain reset)
// Ports: clk, rst (sync, active-high); pwr_down_req/pwr_up_req level requests; sw_ack switch-chain ack;
// sw_en, iso_en, save, restore, dom_rst control outputs; busy, done, err status; pwr_state current state code.
module pwr_seq_ctrl #(
  parameter int ISO_CYC  = 4,
  parameter int SAVE_CYC = 2,
  parameter int RST_CYC  = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_down_req,
  input  logic       pwr_up_req,
  input  logic       sw_ack,
  output logic       sw_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic       dom_rst,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] pwr_state
);
  typedef enum logic [3:0] {
    ON = 4'd0, ISO_ON = 4'd1, SAVE = 4'd2, SW_OFF = 4'd3, OFF = 4'd4,
    SW_ON = 4'd5, DOM_RST = 4'd6, RESTORE = 4'd7, ISO_OFF = 4'd8, ERR = 4'd9
  } state_t;
  localparam logic [7:0] ISO_T  = 8'(ISO_CYC - 1);
  localparam logic [7:0] SAVE_T = 8'(SAVE_CYC - 1);
  localparam logic [7:0] RST_T  = 8'(RST_CYC - 1);
  localparam logic [7:0] TO_T   = 8'(TIMEOUT - 1);
  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic       sw_en_d, iso_en_d, save_d, restore_d, dom_rst_d, busy_d, done_d, err_d;
  assign pwr_state = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ON;
      cnt     <= '0;
      sw_en   <= 1'b1;
      iso_en  <= 1'b0;
      save    <= 1'b0;
      restore <= 1'b0;
      dom_rst <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      sw_en   <= sw_en_d;
      iso_en  <= iso_en_d;
      save    <= save_d;
      restore <= restore_d;
      dom_rst <= dom_rst_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      ON:      state_d = pwr_down_req ? ISO_ON : ON;
      ISO_ON:  state_d = cnt == ISO_T ? SAVE : ISO_ON;
      SAVE:    state_d = cnt == SAVE_T ? SW_OFF : SAVE;
      SW_OFF:  state_d = !sw_ack ? OFF : cnt == TO_T ? ERR : SW_OFF;
      OFF:     state_d = pwr_up_req ? SW_ON : OFF;
      SW_ON:   state_d = sw_ack ? DOM_RST : cnt == TO_T ? ERR : SW_ON;
      DOM_RST: state_d = cnt == RST_T ? RESTORE : DOM_RST;
      RESTORE: state_d = cnt == SAVE_T ? ISO_OFF : RESTORE;
      ISO_OFF: state_d = cnt == ISO_T ? ON : ISO_OFF;
      default: state_d = ERR;
    endcase
    cnt_d = state_d != state ? 8'd0 : cnt == 8'hff ? cnt : cnt + 8'd1;
  end
  // Outputs are decoded from the upcoming state/count and registered, so they line up with pwr_state.
  always_comb begin
    sw_en_d   = !(state_d inside {SW_OFF, OFF, ERR});
    iso_en_d  = state_d != ON;
    save_d    = state_d == SAVE && cnt_d == 8'd0;
    restore_d = state_d == RESTORE && cnt_d == 8'd0;
    dom_rst_d = state_d inside {DOM_RST, ERR};
    busy_d    = !(state_d inside {ON, OFF, ERR});
    done_d    = state_d != state && state_d inside {ON, OFF};
    err_d     = state_d == ERR;
  end
endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb_pwr_seq_ctrl: scoreboard bench for pwr_seq_ctrl against a sequence-level model
module tb_pwr_seq_ctrl;
  localparam int ISO = 4, SV = 2, RC = 4, TO = 255;
  logic clk = 0, rst = 1, pwr_down_req = 0, pwr_up_req = 0, sw_ack = 0;
  logic sw_en, iso_en, save, restore, dom_rst, busy, done, err;
  logic [3:0] pwr_state;
  logic [11:0] expq[$];
  int checks = 0, errors = 0, mode = 0;
  bit live = 0, prev_done = 0;
  pwr_seq_ctrl #(.ISO_CYC(ISO), .SAVE_CYC(SV), .RST_CYC(RC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pwr_down_req(pwr_down_req), .pwr_up_req(pwr_up_req), .sw_ack(sw_ack),
    .sw_en(sw_en), .iso_en(iso_en), .save(save), .restore(restore), .dom_rst(dom_rst),
    .busy(busy), .done(done), .err(err), .pwr_state(pwr_state)
  );
  always #5 clk = ~clk;
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [11:0] v(input int s, input bit first, input bit dn);
    logic sw, iso, sa, rs, dr, bz, er;
    sw  = !(s == 3 || s == 4 || s == 9);
    iso = s != 0;
    sa  = s == 2 && first;
    rs  = s == 7 && first;
    dr  = s == 6 || s == 9;
    bz  = !(s == 0 || s == 4 || s == 9);
    er  = s == 9;
    return {4'(s), sw, iso, sa, rs, dr, bz, dn, er};
  endfunction
  task automatic step(input logic r, input logic dn, input logic up, input logic ack, input logic [11:0] e);
    rst = r; pwr_down_req = dn; pwr_up_req = up; sw_ack = ack;
    @(posedge clk);
    expq.push_back(e);
    #1;
  endtask
  task automatic idle();
    if (mode == 0) step(0, 0, rb(), rb(), v(0, 0, 0));
    else if (mode == 4) step(0, rb(), 0, rb(), v(4, 0, 0));
    else step(0, rb(), rb(), rb(), v(9, 0, 0));
  endtask
  task automatic go_down(input int nack, input logic other);
    step(0, 1, other, rb(), v(1, 0, 0));
    for (int i = 0; i < ISO - 1; i++) step(0, rb(), rb(), rb(), v(1, 0, 0));
    for (int i = 0; i < SV; i++) step(0, rb(), rb(), rb(), v(2, i == 0, 0));
    step(0, rb(), rb(), rb(), v(3, 0, 0));
    for (int k = 0, n = 1; ; k++, n++) begin
      if (k >= nack) begin step(0, rb(), rb(), 0, v(4, 0, 1)); mode = 4; break; end
      if (n == TO) begin step(0, rb(), rb(), 1, v(9, 0, 0)); mode = 9; break; end
      step(0, rb(), rb(), 1, v(3, 0, 0));
    end
  endtask
  task automatic go_up(input int nack, input logic other);
    step(0, other, 1, rb(), v(5, 0, 0));
    for (int k = 0, n = 1; ; k++, n++) begin
      if (k >= nack) begin step(0, rb(), rb(), 1, v(6, 0, 0)); break; end
      if (n == TO) begin step(0, rb(), rb(), 0, v(9, 0, 0)); mode = 9; return; end
      step(0, rb(), rb(), 0, v(5, 0, 0));
    end
    for (int i = 0; i < RC - 1; i++) step(0, rb(), rb(), rb(), v(6, 0, 0));
    for (int i = 0; i < SV; i++) step(0, rb(), rb(), rb(), v(7, i == 0, 0));
    for (int i = 0; i < ISO; i++) step(0, rb(), rb(), rb(), v(8, 0, 0));
    step(0, rb(), rb(), rb(), v(0, 0, 1));
    mode = 0;
  endtask
  task automatic do_reset();
    step(1, rb(), rb(), rb(), v(0, 0, 0));
    mode = 0;
  endtask
  always @(negedge clk) begin
    logic [11:0] got, e;
    got = {pwr_state, sw_en, iso_en, save, restore, dom_rst, busy, done, err};
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got state=%0d vec=%b exp state=%0d vec=%b", $time, got[11:8], got[7:0], e[11:8], e[7:0]);
      end
    end
    if (live) begin
      checks++;
      assert (!(save && restore) && (sw_en && !dom_rst || iso_en) && !(done && prev_done)
              && busy == !(pwr_state inside {4'd0, 4'd4, 4'd9}))
      else begin
        errors++;
        $display("FAIL invariant t=%0t save=%b restore=%b sw_en=%b iso_en=%b dom_rst=%b done=%b/%b busy=%b state=%0d",
                 $time, save, restore, sw_en, iso_en, dom_rst, prev_done, done, busy, pwr_state);
      end
    end
    prev_done = done;
  end
  initial begin
    do_reset();
    do_reset();
    live = 1;
    repeat (3) idle();
    go_down(3, 0);
    repeat (3) idle();
    go_up(1, 0);
    repeat (2) idle();
    go_down(2, 1);
    idle();
    go_up(0, 1);
    go_down(300, rb());
    repeat (20) idle();
    do_reset();
    go_down(0, 0);
    go_up(300, 0);
    repeat (5) idle();
    do_reset();
    step(0, 1, 0, 1, v(1, 0, 0));
    for (int i = 0; i < ISO - 1; i++) step(0, rb(), rb(), rb(), v(1, 0, 0));
    step(0, rb(), rb(), rb(), v(2, 1, 0));
    do_reset();
    repeat (2) idle();
    repeat (40) begin
      repeat ($urandom_range(0, 4)) idle();
      if (mode == 0) go_down($urandom_range(0, 9) == 0 ? 300 : $urandom_range(0, 6), rb());
      else if (mode == 4) go_up($urandom_range(0, 9) == 0 ? 300 : $urandom_range(0, 6), rb());
      else do_reset();
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d required=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
